// File: rtl/sprite_plot_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : sprite_plot_scheduler
// Description : Shares one VGA plot port between N_REQ sprite requesters.
//               Each granted move erases the requester's previously drawn
//               bounding box with BG_COLOUR, then draws the new box from the
//               granted sprite's ROM. Round-robin arbitration; a granted
//               move always runs to completion.
// Ports       : clock, reset          - clock / synchronous active-high reset
//               req                   - per-requester level move request
//               new_x/new_y           - packed top-left position per requester
//               size_w/size_h         - packed (width-1)/(height-1)
//               grant, done, busy     - service handshake / status
//               sprite_x/sprite_y     - ROM address offset for granted sprite
//               sprite_colour         - ROM data, one cycle after the address
//               x_final/y_final/colour/plot - pixel stream to vga_adapter
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_plot_scheduler #(
    parameter int         N_REQ       = 2,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter logic [2:0] TRANSPARENT = 3'b111,
    parameter int         SCREEN_W    = 320,
    parameter int         SCREEN_H    = 240
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [9*N_REQ-1:0]   new_x,
    input  logic [8*N_REQ-1:0]   new_y,
    input  logic [6*N_REQ-1:0]   size_w,
    input  logic [6*N_REQ-1:0]   size_h,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic                 busy,
    output logic [5:0]           sprite_x,
    output logic [5:0]           sprite_y,
    input  logic [2:0]           sprite_colour,
    output logic [8:0]           x_final,
    output logic [7:0]           y_final,
    output logic [2:0]           colour,
    output logic                 plot
);

    localparam int c_IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_ERASE = 3'd1;
    localparam logic [2:0] c_S_DRAW  = 3'd2;
    localparam logic [2:0] c_S_DRAIN = 3'd3;
    localparam logic [2:0] c_S_DONE  = 3'd4;

    logic [2:0]       r_state;
    logic [c_IW-1:0]  r_rr;
    logic [c_IW-1:0]  r_cur;

    // Last drawn box per requester
    logic [8:0]       r_old_x [N_REQ];
    logic [7:0]       r_old_y [N_REQ];
    logic [5:0]       r_old_w [N_REQ];
    logic [5:0]       r_old_h [N_REQ];
    logic [N_REQ-1:0] r_drawn;

    // Box being erased (r_e*) and box being drawn (r_n*) for the current grant
    logic [8:0]       r_ex, r_nx;
    logic [7:0]       r_ey, r_ny;
    logic [5:0]       r_ew, r_eh, r_nw, r_nh;

    logic [5:0]       r_cx, r_cy;
    logic [N_REQ-1:0] r_grant, r_done;

    // Output stage
    logic [8:0]       r_x_final;
    logic [7:0]       r_y_final;
    logic             r_pix;
    logic             r_pix_draw;
    logic             r_pix_clip;

    logic [8:0]       w_nx [N_REQ];
    logic [7:0]       w_ny [N_REQ];
    logic [5:0]       w_nw [N_REQ];
    logic [5:0]       w_nh [N_REQ];

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
            assign w_nx[g] = new_x[9*g +: 9];
            assign w_ny[g] = new_y[8*g +: 8];
            assign w_nw[g] = size_w[6*g +: 6];
            assign w_nh[g] = size_h[6*g +: 6];
        end
    endgenerate

    // Round-robin pick: lowest requester at or above r_rr, else lowest overall.
    logic             w_hit_hi, w_hit_lo;
    logic [c_IW-1:0]  w_pick_hi, w_pick_lo, w_pick;
    logic [N_REQ-1:0] w_pick_oh, w_cur_oh;

    always_comb begin
        w_hit_hi  = 1'b0;
        w_hit_lo  = 1'b0;
        w_pick_hi = '0;
        w_pick_lo = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                w_hit_lo  = 1'b1;
                w_pick_lo = c_IW'(j);
                if (j >= int'(r_rr)) begin
                    w_hit_hi  = 1'b1;
                    w_pick_hi = c_IW'(j);
                end
            end
        end
        w_pick = w_hit_hi ? w_pick_hi : w_pick_lo;
        for (int j = 0; j < N_REQ; j++) begin
            w_pick_oh[j] = (w_pick == c_IW'(j));
            w_cur_oh[j]  = (r_cur == c_IW'(j));
        end
    end

    // Scan geometry for whichever box the current state walks
    logic       w_erasing;
    logic [8:0] w_base_x;
    logic [7:0] w_base_y;
    logic [5:0] w_lim_w, w_lim_h;
    logic [9:0] w_sum_x, w_sum_y;
    logic       w_clip, w_last_x, w_last;

    always_comb begin
        w_erasing = (r_state == c_S_ERASE);
        w_base_x  = w_erasing ? r_ex : r_nx;
        w_base_y  = w_erasing ? r_ey : r_ny;
        w_lim_w   = w_erasing ? r_ew : r_nw;
        w_lim_h   = w_erasing ? r_eh : r_nh;
        w_sum_x   = {1'b0, w_base_x} + {4'b0000, r_cx};
        w_sum_y   = {2'b00, w_base_y} + {4'b0000, r_cy};
        w_clip    = (w_sum_x >= 10'(SCREEN_W)) || (w_sum_y >= 10'(SCREEN_H));
        w_last_x  = (r_cx == w_lim_w);
        w_last    = w_last_x && (r_cy == w_lim_h);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_S_IDLE;
            r_rr       <= '0;
            r_cur      <= '0;
            r_drawn    <= '0;
            r_ex       <= '0;
            r_ey       <= '0;
            r_ew       <= '0;
            r_eh       <= '0;
            r_nx       <= '0;
            r_ny       <= '0;
            r_nw       <= '0;
            r_nh       <= '0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_x_final  <= '0;
            r_y_final  <= '0;
            r_pix      <= 1'b0;
            r_pix_draw <= 1'b0;
            r_pix_clip <= 1'b0;
            for (int i = 0; i < N_REQ; i++) begin
                r_old_x[i] <= '0;
                r_old_y[i] <= '0;
                r_old_w[i] <= '0;
                r_old_h[i] <= '0;
            end
        end else begin
            r_pix  <= 1'b0;
            r_done <= '0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_hit_lo) begin
                        r_cur   <= w_pick;
                        r_grant <= w_pick_oh;
                        r_nx    <= w_nx[w_pick];
                        r_ny    <= w_ny[w_pick];
                        r_nw    <= w_nw[w_pick];
                        r_nh    <= w_nh[w_pick];
                        r_ex    <= r_old_x[w_pick];
                        r_ey    <= r_old_y[w_pick];
                        r_ew    <= r_old_w[w_pick];
                        r_eh    <= r_old_h[w_pick];
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_state <= r_drawn[w_pick] ? c_S_ERASE : c_S_DRAW;
                    end
                end
                c_S_ERASE, c_S_DRAW: begin
                    // One pixel per cycle; clipped pixels still occupy their slot.
                    r_x_final  <= w_sum_x[8:0];
                    r_y_final  <= w_sum_y[7:0];
                    r_pix      <= 1'b1;
                    r_pix_draw <= !w_erasing;
                    r_pix_clip <= w_clip;
                    if (w_last_x) begin
                        r_cx <= '0;
                        r_cy <= w_last ? 6'd0 : r_cy + 6'd1;
                    end else begin
                        r_cx <= r_cx + 6'd1;
                    end
                    if (w_last) begin
                        r_state <= w_erasing ? c_S_DRAW : c_S_DRAIN;
                    end
                end
                c_S_DRAIN: begin
                    // Output stage is showing the last drawn pixel this cycle.
                    r_done  <= w_cur_oh;
                    r_state <= c_S_DONE;
                end
                c_S_DONE: begin
                    r_old_x[r_cur] <= r_nx;
                    r_old_y[r_cur] <= r_ny;
                    r_old_w[r_cur] <= r_nw;
                    r_old_h[r_cur] <= r_nh;
                    r_drawn[r_cur] <= 1'b1;
                    r_grant        <= '0;
                    r_rr           <= (r_cur == c_IW'(N_REQ - 1)) ? '0 : r_cur + c_IW'(1);
                    r_state        <= c_S_IDLE;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign grant    = r_grant;
    assign done     = r_done;
    assign busy     = (r_state != c_S_IDLE);
    assign sprite_x = r_cx;
    assign sprite_y = r_cy;
    assign x_final  = r_x_final;
    assign y_final  = r_y_final;

    // ROM data arrives in the same cycle the registered coordinates for that
    // address are presented, so colour and the transparency test use it
    // directly to keep a single cycle of address-to-pixel latency.
    assign colour = (r_pix && r_pix_draw) ? sprite_colour : BG_COLOUR;
    assign plot   = r_pix && !r_pix_clip &&
                    !(r_pix_draw && (sprite_colour == TRANSPARENT));

endmodule
`default_nettype wire

// File: doc/sprite_plot_scheduler.md
# sprite_plot_scheduler

Shares the single VGA plot port between N sprite requesters (car, pedestrians) and sequences each move as an erase of the old bounding box followed by a draw of the new one. It replaces per-sprite datapath counters and the erase/draw logic in `control`. It sits between the sprite logic and `vga_adapter`: it addresses the granted sprite's `sprite_ram` and drives x/y/colour/plot. Arbitration is round-robin; a granted move always completes.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters (1..4).
- `BG_COLOUR`, 3'b000: colour plotted during erase.
- `TRANSPARENT`, 3'b111: sprite colour that is never plotted.
- `SCREEN_W`, 320 / `SCREEN_H`, 240: pixels at or beyond these limits are suppressed.

Ports:
- `clock`  in  1  system tick; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  N_REQ  per-requester move request, level.
- `new_x`  in  9*N_REQ  packed top-left x of requester i, bits [9i+8:9i].
- `new_y`  in  8*N_REQ  packed top-left y.
- `size_w` / `size_h`  in  6*N_REQ each  sprite width−1 / height−1 (e.g. car 26/47).
- `grant`  out  N_REQ  one-hot, high from arbitration until done.
- `done`  out  N_REQ  one-hot single-cycle pulse at end of service.
- `busy`  out  1  high whenever the state is not IDLE.
- `sprite_x` / `sprite_y`  out  6 each  pixel offset into the granted sprite ROM.
- `sprite_colour`  in  3  ROM data; valid exactly one cycle after `sprite_x`/`sprite_y`.
- `x_final`  out  9, `y_final`  out  8, `colour`  out  3, `plot`  out  1  to `vga_adapter`.

## Operation
- **States:** IDLE, ERASE, DRAW, DRAIN, DONE.
- **Per-requester registers:** `old_x`, `old_y`, `old_w`, `old_h`, `drawn` flag. `drawn` is cleared by reset.
- **Round-robin pointer `rr`:** reset value 0.
- **IDLE, any `req` high:**
  - Pick the first requester with `req` high, searching from `rr` upward with wrap.
  - Latch its `new_x`, `new_y`, `size_w`, `size_h`.
  - Set `grant` one-hot.
  - Go to ERASE if `drawn[i]`, else DRAW.
- **ERASE:**
  - Scan `old_w`/`old_h` row-major; `cx` is fastest, starting at (0,0).
  - Each cycle: `x_final` = `old_x`+`cx`, `y_final` = `old_y`+`cy`, `colour` = `BG_COLOUR`, `plot` = 1 unless clipped.
  - After the last pixel, go to DRAW with `cx`=`cy`=0.
- **DRAW:**
  - Each cycle, issue `sprite_x`=`cx`, `sprite_y`=`cy`.
  - The output stage registers one cycle later: `x_final` = latched x+`cx`, `y_final` = latched y+`cy`, `colour` = `sprite_colour`.
  - `plot` = 1 unless the colour equals `TRANSPARENT` or the pixel is clipped.
  - After the last address, go to DRAIN; DRAIN emits the final pixel.
- **DONE:**
  - Copy the latched position and size into `old_*` and set `drawn[i]`.
  - Pulse `done[i]` and clear `grant`.
  - Set `rr` = (i+1) mod N_REQ, then go to IDLE.
- **Arithmetic:** coordinate sums are computed 10 bits wide. A pixel is clipped when x ≥ `SCREEN_W` or y ≥ `SCREEN_H`; clipped pixels still take one cycle.
- **Boundaries:**
  - `req` dropping mid-service is ignored; service completes.
  - `req` held through DONE is re-arbitrated normally; a same-cycle request from another requester wins if it comes earlier in rr order.
  - A size of 0/0 is a 1×1 sprite.
  - `new_*`/`size_*` changing mid-service are ignored until the next grant.
- **Reset (any state, including mid-scan):**
  - Next cycle: IDLE, `grant`=0, `done`=0, `busy`=0, `plot`=0.
  - `x_final`=0, `y_final`=0, `colour`=`BG_COLOUR`, `sprite_x`=`sprite_y`=0.
  - `rr`=0, all `drawn`=0. No partial pixels are emitted.

## Timing
- Arbitration: `req` sampled high in IDLE at edge k → `grant` and `busy` high after edge k.
- ERASE: exactly (w+1)(h+1) cycles of `plot`-eligible output.
- DRAW address phase: (h+1)(w+1) cycles; pixel outputs lag addresses by 1 cycle, and DRAIN covers the last one.
- DONE: 1 cycle; `done` is high in that cycle, and `grant` and `busy` drop at the following edge.
- Total service: 1 + [erase] + P + 1 + 1 cycles, where P = (w+1)(h+1).
- Back-to-back: the next grant comes no earlier than the cycle after DONE; there is at least one idle cycle between services.
- `plot` is never high in IDLE or DONE.

## Test plan
- **Reset state:** assert `reset` 2 cycles → `plot`=0, `grant`=0, `busy`=0, `x_final`=0, `colour`=000, `rr`=0.
- **First draw, no erase:** req0, `new`=(10,20), size 1/1, ROM returns 3'b010 → 4 plots at (10,20)(11,20)(10,21)(11,21), colour 010, each one cycle after its address. `done[0]` pulses 7 cycles after `req` is sampled.
- **Move with erase:** second req0 to (12,20) → 4 BG plots at the old box, then 4 draw plots at the new box; `done` pulses after 11 cycles.
- **Clipping and transparency:** x=318, size_w 3 → pixels x=320,321 take cycles but `plot`=0. A ROM value of 3'b111 → `plot`=0 on that pixel.
- **Round robin:** req0 and req1 held continuously → grant order 0,1,0,1. `grant` is never two-hot and is always 0 for ≥1 cycle between services.
- **Reset mid-draw:** assert `reset` during the 3rd DRAW pixel → `plot`=0 the next cycle. The next req0 draws without erasing, since `drawn` was cleared.
